module_demux: RTL and testbench
===============================

# module_demux

Receive-side counterpart of the display time-multiplexer. One 4-bit bus carries two values alternately, and a slow selector square wave (nominally 1 kHz, asynchronous to the system clock) marks which value is on the bus. This block synchronizes the selector, waits for the bus to settle after each selector transition, and latches the value into the register for that phase. It pulses a strobe per captured value and a pair strobe when a complete i-then-p pair is held. It sits between the multiplexed bus and any logic that needs both values in parallel (checker, debug LEDs, loop-back test).

## Interface
Parameters:
- SETTLE_CYCLES, 16: system-clock cycles from the detected selector edge to capture. Legal range is ≥1.
- W, 4: bus width.

Ports:
- clk  in  1  system clock. One clock only; every register in the block is on clk.
- rst  in  1  asynchronous, active-high reset.
- sel_in  in  1  selector from the mux side. 0 means i is on the bus, 1 means p is on the bus. Asynchronous to clk.
- w  in  W  multiplexed bus. Asynchronous to clk.
- i_out  out  W  last value captured in phase 0.
- p_out  out  W  last value captured in phase 1.
- i_valid  out  1  one-cycle pulse when i_out updates.
- p_valid  out  1  one-cycle pulse when p_out updates.
- pair_valid  out  1  one-cycle pulse, coincident with p_valid, when the p capture follows an i capture.
- err  out  1  one-cycle pulse on a rejected capture. Only driven under DEMUX_STABLE_CHECK_EN; otherwise constant 0.

## Operation
- Synchronization:
  - sel_in passes through 2 flops to give sel_s; sel_d is sel_s delayed by one cycle.
  - w passes through 2 flops to give w_s, so it stays aligned with sel_s.
  - An edge is detected when sel_s != sel_d.
- State machine, IDLE / SETTLE:
  - IDLE, on edge: go to SETTLE, cnt = SETTLE_CYCLES-1, phase = sel_s.
  - SETTLE, on edge: restart. cnt = SETTLE_CYCLES-1, phase = sel_s. The pending capture is aborted with no strobe.
  - SETTLE, cnt>0, no edge: cnt decrements.
  - SETTLE, cnt==0, no edge: capture w_s, then return to IDLE.
- Capture:
  - phase 0: i_out ← w_s, i_valid=1, have_i ← 1.
  - phase 1: p_out ← w_s, p_valid=1. pair_valid = have_i, then have_i ← 0.
- Counter width is $clog2(SETTLE_CYCLES+1). When SETTLE_CYCLES=1, capture happens on the cycle after the edge.
- No capture occurs without a selector edge. The first phase after reset is not captured unless the synchronized selector changes.
- Reset applies asynchronously at any time, including mid-SETTLE. State goes to IDLE, cnt, phase and have_i go to 0, all sync flops go to 0, and all outputs go to 0. The pending capture is lost.
- Consequence of the sync flops resetting to 0: if sel_in=1 when reset deasserts, an edge is detected and p is captured SETTLE_CYCLES later.

## Timing
- E is the clk edge at which the changed selector is first registered into sel_s. This is 2–3 cycles after sel_in changes.
- Capture registers update at clk edge E+SETTLE_CYCLES.
- The strobe is high during the cycle that follows that edge.
- Captured data is the w_s present immediately before the capture edge. That is w as sampled 2 cycles earlier.
- Minimum selector half-period for guaranteed capture is SETTLE_CYCLES+3 cycles. Shorter phases are aborted.
- i_valid and p_valid are never high together. pair_valid only ever coincides with p_valid.

## Configuration
- DEMUX_STABLE_CHECK_EN defined:
  - The block tracks how many consecutive cycles w_s has been unchanged, saturating at 4.
  - At capture, if w_s has been stable for fewer than min(SETTLE_CYCLES,4) cycles, the capture is rejected. Outputs are unchanged, no valid strobes fire, have_i is unchanged, err pulses one cycle, and the state returns to IDLE.
- DEMUX_STABLE_CHECK_EN not defined: the stability counter is absent, err is tied 0, and every completed SETTLE captures.

## Test plan
All scenarios use SETTLE_CYCLES=16.

1. Reset: assert rst mid-operation with arbitrary inputs. All outputs read 0 immediately (asynchronous). With sel_in=0 held after release, there are no strobes.
2. Basic pair sequence, starting from sel_in=0 after reset:
   - sel 0→1 with w=0xA: p_out=0xA, p_valid only.
   - 1→0 with w=0x5: i_out=0x5, i_valid.
   - 0→1 with w=0xC: p_out=0xC, p_valid and pair_valid together.
3. Latency: toggle sel_in with w stable. The strobe rises exactly 16 cycles after the cycle in which sel_s changes, which is 18–19 cycles after the sel_in change. Check with sel_in changed both on and off clk-aligned edges.
4. Abort: toggle sel_in 0→1, then back to 0 five cycles later, with w=0x3. There is no p capture. i_out=0x3 with i_valid, 16 cycles after the second detected edge.
5. Reset mid-SETTLE: assert rst 8 cycles after an edge, then release. No strobe from the aborted capture, and all outputs stay 0.
6. Stability check, only with DEMUX_STABLE_CHECK_EN defined: change w 2 cycles before the capture edge. err pulses, there are no valid strobes, and i_out/p_out are unchanged. Without the macro, the same stimulus captures the new w and err stays 0.

Source files
------------

// File: rtl/module_demux.sv
// module_demux: receive side of a two-value time-multiplexed bus.
// The selector and bus are synchronized. After each selector edge the block waits
// SETTLE_CYCLES, then latches the bus into i_out (sel=0) or p_out (sel=1).
// It pulses a valid strobe for each capture, and pair_valid for an i-then-p pair.
// Optional feature: define DEMUX_STABLE_CHECK_EN to reject captures of a bus
// that changed too recently. A rejected capture gives an err pulse instead of a strobe.
module module_demux #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned W             = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sel_in,
  input  logic [W-1:0] w,
  output logic [W-1:0] i_out,
  output logic [W-1:0] p_out,
  output logic         i_valid,
  output logic         p_valid,
  output logic         pair_valid,
  output logic         err
);
  localparam int unsigned   CW      = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CntLoad = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StSettle} state_e;

  logic          sel_meta_q, sel_s_q;
  logic [W-1:0]  w_meta_q, w_s_q;
  logic          sel_edge;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;
  logic          have_i_q, have_i_d;
  logic          capture, stable, commit;
  logic [W-1:0]  i_d, p_d;
  logic          i_valid_d, p_valid_d, pair_valid_d;

  // Two-flop synchronizers for the selector and the bus, kept aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_meta_q <= 1'b0;
      sel_s_q    <= 1'b0;
      w_meta_q   <= '0;
      w_s_q      <= '0;
    end else begin
      sel_meta_q <= sel_in;
      sel_s_q    <= sel_meta_q;
      w_meta_q   <= w;
      w_s_q      <= w_meta_q;
    end
  end

  // This compares sel_s with the value about to enter it. It gives the sel_s-vs-delayed-sel_s
  // edge one cycle early, so the capture edge lands exactly SETTLE_CYCLES after sel_s changes.
  assign sel_edge = sel_meta_q ^ sel_s_q;

  // Settle FSM: an edge (re)starts the countdown, and terminal count with no edge captures
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sel_edge) begin
          state_d = StSettle;
          cnt_d   = CntLoad;
          phase_d = sel_meta_q;
        end
      end
      StSettle: begin
        if (sel_edge) begin
          cnt_d   = CntLoad;
          phase_d = sel_meta_q;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          capture = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Capture routing: w_s goes to the register for the settled phase
  always_comb begin
    i_d          = i_out;
    p_d          = p_out;
    have_i_d     = have_i_q;
    i_valid_d    = 1'b0;
    p_valid_d    = 1'b0;
    pair_valid_d = 1'b0;
    commit       = capture & stable;
    if (commit) begin
      if (!phase_q) begin
        i_d       = w_s_q;
        i_valid_d = 1'b1;
        have_i_d  = 1'b1;
      end else begin
        p_d          = w_s_q;
        p_valid_d    = 1'b1;
        pair_valid_d = have_i_q;
        have_i_d     = 1'b0;
      end
    end
  end

  // State, capture registers and strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      phase_q    <= 1'b0;
      have_i_q   <= 1'b0;
      i_out      <= '0;
      p_out      <= '0;
      i_valid    <= 1'b0;
      p_valid    <= 1'b0;
      pair_valid <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      have_i_q   <= have_i_d;
      i_out      <= i_d;
      p_out      <= p_d;
      i_valid    <= i_valid_d;
      p_valid    <= p_valid_d;
      pair_valid <= pair_valid_d;
    end
  end

`ifdef DEMUX_STABLE_CHECK_EN
  localparam logic [2:0] StabMin = (SETTLE_CYCLES < 4) ? 3'(SETTLE_CYCLES) : 3'd4;

  logic [2:0] stab_q, stab_d;
  logic       err_q;

  // Count the cycles w_s has held its value, saturating at 4
  always_comb begin
    stab_d = stab_q;
    if (w_meta_q != w_s_q) begin
      stab_d = '0;
    end else if (stab_q != 3'd4) begin
      stab_d = stab_q + 3'd1;
    end
  end

  // Stability counter and reject strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stab_q <= '0;
      err_q  <= 1'b0;
    end else begin
      stab_q <= stab_d;
      err_q  <= capture & ~stable;
    end
  end

  assign stable = (stab_q >= StabMin);
  assign err    = err_q;
`else
  assign stable = 1'b1;
  assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_module_demux.sv
// Testbench for module_demux (SETTLE_CYCLES=16). It combines directed vector tables
// with random selector/bus/reset stimulus. A history-based reference model is
// compared against the DUT on every falling clock edge.
module tb_module_demux;
  localparam int S = 16;
  localparam int W = 4;

  logic         clk    = 1'b0;
  logic         rst    = 1'b1;
  logic         sel_in = 1'b0;
  logic [W-1:0] w      = '0;
  logic [W-1:0] i_out, p_out;
  logic         i_valid, p_valid, pair_valid, err;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  module_demux #(.SETTLE_CYCLES(S), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .sel_in    (sel_in),
    .w         (w),
    .i_out     (i_out),
    .p_out     (p_out),
    .i_valid   (i_valid),
    .p_valid   (p_valid),
    .pair_valid(pair_valid),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Reference model: inputs are sampled at every rising edge since reset. Index 0 holds
  // the reset value. sel_s/w_s after edge k equal the samples taken at edge k-1.
  logic         s_hist[$];
  logic [W-1:0] w_hist[$];
  int           last_chg;
  logic [W-1:0] m_i, m_p;
  logic         m_iv, m_pv, m_pair, m_err, m_have_i;

  function automatic logic sel_s_at(int k);
    return (k <= 0) ? 1'b0 : s_hist[k-1];
  endfunction

  function automatic logic [W-1:0] w_s_at(int k);
    return (k <= 0) ? '0 : w_hist[k-1];
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int n, k, j;
    logic ok;
    if (rst) begin
      s_hist.delete();
      w_hist.delete();
      s_hist.push_back(1'b0);
      w_hist.push_back('0);
      last_chg = -1;
      m_i = '0; m_p = '0;
      m_iv = 1'b0; m_pv = 1'b0; m_pair = 1'b0; m_err = 1'b0; m_have_i = 1'b0;
    end else begin
      s_hist.push_back(sel_in);
      w_hist.push_back(w);
      n = s_hist.size() - 1;
      m_iv = 1'b0; m_pv = 1'b0; m_pair = 1'b0; m_err = 1'b0;
      if (sel_s_at(n) != sel_s_at(n - 1)) last_chg = n;
      // Capture S edges after the latest sel_s change, using the w_s held just before
      if (last_chg >= 0 && n - last_chg == S) begin
        k = 0;
        j = n - 1;
        while (k < 4 && j >= 1 && w_s_at(j) == w_s_at(j - 1)) begin
          k++;
          j--;
        end
        ok = 1'b1;
`ifdef DEMUX_STABLE_CHECK_EN
        ok = (k >= ((S < 4) ? S : 4));
`endif
        if (!ok) begin
          m_err = 1'b1;
        end else if (sel_s_at(n) == 1'b0) begin
          m_i = w_s_at(n - 1); m_iv = 1'b1; m_have_i = 1'b1;
        end else begin
          m_p = w_s_at(n - 1); m_pv = 1'b1; m_pair = m_have_i; m_have_i = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge and compare everything against the model
  task automatic cyc();
    @(negedge clk);
    if (chk_en)
      check("scoreboard", {20'd0, i_out, p_out, i_valid, p_valid, pair_valid, err},
            {20'd0, m_i, m_p, m_iv, m_pv, m_pair, m_err});
  endtask

  // Count falling edges until any strobe is seen, or return -1 after 60 cycles
  task automatic wait_strobe(output int lat);
    bit found = 1'b0;
    lat = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      cyc();
      lat++;
      if (i_valid | p_valid | err) found = 1'b1;
    end
    if (!found) lat = -1;
  endtask

  task automatic check_zero(input string name);
    check(name, {20'd0, i_out, p_out, i_valid, p_valid, pair_valid, err}, 32'd0);
  endtask

  typedef struct {
    logic         sel;
    logic [W-1:0] w;
    logic [W-1:0] exp_i;
    logic [W-1:0] exp_p;
    logic [3:0]   exp_flags;  // {i_valid, p_valid, pair_valid, err}
  } vec_t;

  vec_t vecs[4];
  int   offs[4];

  initial begin
    int lat, strobes, d;

    vecs[0] = '{1'b1, 4'hA, 4'h0, 4'hA, 4'b0100};
    vecs[1] = '{1'b0, 4'h5, 4'h5, 4'hA, 4'b1000};
    vecs[2] = '{1'b1, 4'hC, 4'h5, 4'hC, 4'b0110};
    vecs[3] = '{1'b0, 4'h6, 4'h6, 4'hC, 4'b1000};
    offs    = '{1, 7, 3, 9};

    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    chk_en = 1'b1;
    check_zero("reset state");
    repeat (4) cyc();

    // Basic pair sequence from sel_in=0
    for (int t = 0; t < 4; t++) begin
      w = vecs[t].w;
      repeat (4) cyc();
      #1 sel_in = vecs[t].sel;
      wait_strobe(lat);
      check($sformatf("vec%0d latency", t), lat, 18);
      check($sformatf("vec%0d i_out", t), i_out, vecs[t].exp_i);
      check($sformatf("vec%0d p_out", t), p_out, vecs[t].exp_p);
      check($sformatf("vec%0d flags", t), {i_valid, p_valid, pair_valid, err}, vecs[t].exp_flags);
      repeat (4) cyc();
    end

    // Abort: a short p phase is dropped, and the i capture counts from the second edge
    w = 4'h3;
    repeat (4) cyc();
    #1 sel_in = 1'b1;
    repeat (5) cyc();
    #1 sel_in = 1'b0;
    wait_strobe(lat);
    check("abort latency", lat, 18);
    check("abort i_out", i_out, 4'h3);
    check("abort p_out", p_out, 4'hC);
    check("abort flags", {i_valid, p_valid, pair_valid, err}, 4'b1000);
    repeat (4) cyc();

    // The bus changes two cycles before the capture edge
    w = 4'h7;
    repeat (4) cyc();
    #1 sel_in = 1'b1;
    repeat (15) cyc();
    #1 w = 4'h8;
    wait_strobe(lat);
    check("unstable latency", lat, 3);
    check("unstable i_out", i_out, 4'h3);
`ifdef DEMUX_STABLE_CHECK_EN
    check("unstable p_out", p_out, 4'hC);
    check("unstable flags", {i_valid, p_valid, pair_valid, err}, 4'b0001);
`else
    check("unstable p_out", p_out, 4'h8);
    check("unstable flags", {i_valid, p_valid, pair_valid, err}, 4'b0110);
`endif
    repeat (4) cyc();

    // Latency with the selector changed before and after the next rising edge
    for (int t = 0; t < 4; t++) begin
      repeat (4) cyc();
      #(offs[t]) sel_in = ~sel_in;
      wait_strobe(lat);
      check($sformatf("latency off=%0d", offs[t]), lat, (offs[t] > 5) ? 19 : 18);
      check($sformatf("latency off=%0d err", offs[t]), err, 1'b0);
    end
    repeat (4) cyc();

    // Reset 8 cycles after a detected edge loses the pending capture
    #1 sel_in = 1'b0;
    repeat (10) cyc();
    #1 rst = 1'b1;
    #1 check_zero("reset mid-settle");
    cyc();
    cyc();
    #1 rst = 1'b0;
    strobes = 0;
    repeat (30) begin
      cyc();
      if (i_valid | p_valid | pair_valid | err) strobes++;
    end
    check("mid-settle strobes", strobes, 0);
    check_zero("mid-settle outputs");

    // Random selector toggles (including aborts), bus changes and resets
    for (int it = 0; it < 250; it++) begin
      int a;
      a = $urandom_range(0, 19);
      d = $urandom_range(1, 7);
      if (d >= 5) d++;
      if (a == 0) begin
        #(d) rst = 1'b1;
        #1 check_zero("random reset");
        cyc();
        cyc();
        #($urandom_range(1, 4));
        sel_in = 1'($urandom_range(0, 1));
        w      = 4'($urandom_range(0, 15));
        rst    = 1'b0;
        cyc();
      end else if (a <= 12) begin
        #(d) sel_in = ~sel_in;
        if ($urandom_range(0, 3) == 0) w = 4'($urandom_range(0, 15));
        repeat ($urandom_range(1, 24)) begin
          cyc();
          if ($urandom_range(0, 7) == 0) w = 4'($urandom_range(0, 15));
        end
      end else begin
        #(d) w = 4'($urandom_range(0, 15));
        repeat ($urandom_range(1, 6)) cyc();
      end
    end
    repeat (25) cyc();

    // Reset with arbitrary inputs, then sel_in=0 held: outputs clear and no strobes follow
    sel_in = 1'b1;
    w      = 4'hF;
    #2 rst = 1'b1;
    #1 check_zero("async reset");
    sel_in = 1'b0;
    cyc();
    cyc();
    #2 rst = 1'b0;
    strobes = 0;
    repeat (40) begin
      cyc();
      if (i_valid | p_valid | pair_valid | err) strobes++;
    end
    check("post-reset strobes", strobes, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
